// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive packet scheduler: header field
// layout, sync nibble and the scheduler state type.
package spi_pkg;

    localparam logic [3:0] SYNC_NIB = 4'hA;

    // Header word layout: [15:12] sync, [11:8] channel, [7:0] payload length.
    localparam int SYNC_MSB = 15;
    localparam int SYNC_LSB = 12;
    localparam int CH_MSB   = 11;
    localparam int CH_LSB   = 8;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 0;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } sched_state_t;

    // True when the word carries the header sync nibble.
    function automatic logic is_sync(input logic [15:0] w);
        return w[SYNC_MSB:SYNC_LSB] == SYNC_NIB;
    endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Registered 16-bit word FIFO (no fall-through). Pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
// Flush beats push; a push in the flush cycle leaves exactly that word.
module spi_word_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [15:0]                din,
    output logic                       full,
    output logic                       empty,
    output logic [15:0]                head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

    // Storage write: a flush restarts at slot 0, otherwise write at the tail.
    always_ff @(posedge clk) begin
        if (push && (flush || !full)) begin
            mem[flush ? {AW{1'b0}} : wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update: flush empties the FIFO (keeping a simultaneous push).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_rx_sched.sv
// Packet scheduler: buffers received words, parses header-framed packets and
// hands payload words to one of NCH consumers over valid/ready.
//
// Handshake: ch_valid[c] high offers ch_data to channel c; a word transfers
// on a rising edge where ch_valid[c] & ch_ready[c]. While offered and not
// taken, ch_data holds; valid only drops without a transfer on overflow,
// idle timeout or reset.
module spi_rx_sched
    import spi_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                word_in,
    input  logic                       word_stb,
    output logic [15:0]                ch_data,
    output logic [NCH-1:0]             ch_valid,
    input  logic [NCH-1:0]             ch_ready,
    output logic                       pkt_done,
    output logic [15:0]                pkt_cnt,
    output logic [7:0]                 err_cnt,
    output sched_state_t               dbg_state,
    output logic [$clog2(DEPTH):0]     dbg_fifo_count
);

    localparam int IW = $clog2(TIMEOUT);

    sched_state_t   state;
    logic [3:0]     ch;
    logic [7:0]     rem;
    logic [IW-1:0]  idle;

    logic           fifo_full;
    logic           fifo_empty;
    logic [15:0]    head;
    logic           fifo_pop;
    logic           pop_req;
    logic           overflow;
    logic           accept;
    logic           timeout_hit;
    logic           err_evt;
    logic           done_evt;

    logic           hdr_sync;
    logic [3:0]     hdr_ch;
    logic [7:0]     hdr_len;
    logic           hdr_ch_bad;

    assign overflow  = word_stb && fifo_full;
    assign fifo_pop  = pop_req && !overflow;
    assign ch_data   = head;
    assign dbg_state = state;

    assign hdr_sync   = is_sync(head);
    assign hdr_ch     = head[CH_MSB:CH_LSB];
    assign hdr_len    = head[LEN_MSB:LEN_LSB];
    assign hdr_ch_bad = (32'(hdr_ch) >= 32'(NCH));

    spi_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (word_stb),
        .pop   (fifo_pop),
        .flush (overflow),
        .din   (word_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head),
        .count (dbg_fifo_count)
    );

    // Offer the head word to the latched channel while a payload is in flight.
    always_comb begin
        ch_valid = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_valid[i] = (state == PAYLOAD) && !fifo_empty && (ch == 4'(i));
        end
    end

    assign accept = |(ch_valid & ch_ready);

    // Head consumption: HUNT/DROP take every word, PAYLOAD waits for ready.
    always_comb begin
        pop_req = 1'b0;
        case (state)
            HUNT:    pop_req = !fifo_empty;
            PAYLOAD: pop_req = accept;
            DROP:    pop_req = !fifo_empty;
            default: pop_req = 1'b0;
        endcase
    end

    // Event decode for the counters; overflow suppresses any pop this cycle.
    always_comb begin
        timeout_hit = (state != HUNT) && fifo_empty && !word_stb
                      && (idle == IW'(TIMEOUT - 1));
        err_evt  = overflow || timeout_hit
                   || ((state == HUNT) && !fifo_empty && !overflow && !hdr_sync);
        done_evt = !overflow
                   && (((state == HUNT) && !fifo_empty && hdr_sync && (hdr_len == 8'd0))
                       || ((state == PAYLOAD) && accept && (rem == 8'd1)));
    end

    // Scheduler FSM with idle timer and packet/error counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            ch       <= '0;
            rem      <= '0;
            idle     <= '0;
            pkt_done <= 1'b0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            pkt_done <= done_evt;
            if (done_evt) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (err_evt && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (overflow) begin
                state <= HUNT;
                idle  <= '0;
            end else begin
                // The timer only runs while a packet is open and starved.
                if (word_stb || (state == HUNT)) begin
                    idle <= '0;
                end else if (fifo_empty) begin
                    idle <= timeout_hit ? '0 : idle + 1'b1;
                end

                case (state)
                    HUNT: begin
                        if (!fifo_empty && hdr_sync && (hdr_len != 8'd0)) begin
                            rem <= hdr_len;
                            if (hdr_ch_bad) begin
                                state <= DROP;
                            end else begin
                                ch    <= hdr_ch;
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (timeout_hit) begin
                            state <= HUNT;
                        end else if (accept) begin
                            rem <= rem - 8'd1;
                            if (rem == 8'd1) begin
                                state <= HUNT;
                            end
                        end
                    end
                    DROP: begin
                        if (timeout_hit) begin
                            state <= HUNT;
                        end else if (!fifo_empty) begin
                            rem <= rem - 8'd1;
                            if (rem == 8'd1) begin
                                state <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_rx_sched.md
# spi_rx_sched

Packet scheduler that sits in the `clk` domain downstream of the SPI slave receiver's clock-domain crossing. It buffers received 16-bit words in a small FIFO, parses them into framed packets, and dispatches each packet's payload words to one of `NCH` consumer channels over valid/ready. On overflow the FIFO is flushed so consumers receive only fresh data; framing is then resynchronised on the next header. Stalled or truncated packets are aborted by an idle timeout.

## Interface
- `NCH`, 4: number of consumer channels, 1..16.
- `DEPTH`, 16: FIFO depth in words; power of two, ≥4.
- `TIMEOUT`, 1024: idle `clk` cycles before a partial packet is aborted; ≥2.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `word_in`  in  16  received word; valid only when `word_stb` is high.
- `word_stb`  in  1  one-cycle strobe, one per received word.
- `ch_data`  out  16  FIFO head word; shared by all channels.
- `ch_valid`  out  NCH  one-hot valid for the selected channel.
- `ch_ready`  in  NCH  per-channel ready.
- `pkt_done`  out  1  one-cycle pulse when a packet's last payload word is popped (or on a zero-length header).
- `pkt_cnt`  out  16  completed packets; wraps.
- `err_cnt`  out  8  errors (bad sync, overflow, timeout); saturates at 255.

## Operation
- **Header word format:**
  - [15:12] = 4'hA (sync).
  - [11:8] = channel.
  - [7:0] = payload length `N` (0..255).
- **FIFO:** registered, no fall-through.
  - `word_stb` writes at the next edge.
  - A pop occurs at the edge where the FSM consumes the head.
- **Overflow:** `word_stb` arrives while the FIFO is full (pop ignored that cycle). Then:
  - Flush to empty and write `word_in` as the only entry.
  - Force state to HUNT.
  - Increment `err_cnt`.
  - Overflow wins over any simultaneous pop or FSM transition.
- **FSM states:** HUNT, PAYLOAD, DROP.
  - **HUNT:** pop the head every cycle the FIFO is non-empty.
    - Head[15:12] ≠ A: increment `err_cnt`, stay in HUNT.
    - Valid header with `N` = 0: pulse `pkt_done`, increment `pkt_cnt`, stay in HUNT.
    - Valid header with channel ≥ `NCH`: latch `N`, go to DROP.
    - Otherwise: latch channel and `N` into `rem`, go to PAYLOAD.
  - **PAYLOAD:** `ch_valid[ch]` = FIFO non-empty; all other bits 0.
    - Pop when `ch_valid[ch] & ch_ready[ch]`; decrement `rem`.
    - On popping the final word (`rem` = 1): pulse `pkt_done`, increment `pkt_cnt`, go to HUNT.
    - Payload words are not inspected. Words with value 0xAxxx are data.
  - **DROP:** pop every cycle the FIFO is non-empty, decrement `rem`.
    - At `rem` = 1 pop: go to HUNT. No `pkt_done`, no error.
- **Timeout:**
  - `idle` counter counts only in PAYLOAD/DROP, and only while the FIFO is empty.
  - It clears on `word_stb` and in HUNT. Consumer backpressure never causes a timeout.
  - At `idle` = `TIMEOUT`−1: go to HUNT, increment `err_cnt`, clear `idle`.
- `ch_valid` is 0 in HUNT and DROP. `ch_data` is the FIFO head regardless of state.

## Timing
- **Reset values:**
  - Outputs: `ch_valid` = 0, `pkt_done` = 0, `pkt_cnt` = 0, `err_cnt` = 0. `ch_data` is don't-care.
  - Internal: FIFO empty, state HUNT, `idle` = 0, `rem` = 0.
  - Reset mid-packet discards everything. No `pkt_done` is issued.
- **Latency:**
  - Header strobed in cycle t is written at edge t+1 and popped at edge t+2. State is PAYLOAD from t+2.
  - A payload word strobed in cycle t+1 is presented on `ch_valid` in cycle t+2.
  - Minimum strobe-to-`ch_valid` latency for a payload word is 1 cycle once in PAYLOAD.
- **Handshake:**
  - `ch_data` is stable while `ch_valid` is high and not accepted.
  - `ch_valid` never deasserts without acceptance, except on overflow, timeout or reset.
- **Throughput:** simultaneous write and pop in the same cycle are both honoured (count unchanged) when not full. Sustains one word per cycle.
- **Counters:** `pkt_cnt` and `err_cnt` update at the same edge as the causing pop or event. Multiple errors in one cycle count once.

## Structure
- Shared package `spi_pkg`:
  - `SYNC_NIB` = 4'hA.
  - Header field positions.
  - FSM state enum `sched_state_t` {HUNT, PAYLOAD, DROP}.
- Sub-module `spi_word_fifo`:
  - Parameterised `DEPTH`, width 16.
  - `push`, `pop`, `flush`, `full`, `empty`, `head`.
  - Pointers are log2(`DEPTH`)+1 bits, with an MSB wrap bit for full/empty.
  - `flush` has priority over `push`; `push` with `flush` leaves count = 1.
- Top level holds the FSM, `rem`, `idle` and the counters.

## Test plan
- **Basic dispatch:** strobe 0xA103, 0x1111, 0x2222, 0x3333 with `ch_ready[1]` = 1. Expect `ch_valid` = 4'b0010 for exactly 3 words with those values, `pkt_done` pulse on 0x3333, `pkt_cnt` = 1, `err_cnt` = 0.
- **Backpressure:** same packet, `ch_ready[1]` low for 2000 cycles after the first word. Expect `ch_data` held at 0x1111, no timeout, `err_cnt` = 0. On release the remaining words are delivered in order.
- **Bad sync / bad channel:**
  - Strobe 0x1234: `err_cnt` = 1.
  - Then 0xA502, 0xAAAA, 0xBBBB with `NCH` = 4: both payload words dropped, `ch_valid` never set, `pkt_cnt` unchanged.
  - Then 0xA000: `pkt_done`, `pkt_cnt` = 1.
- **Overflow:** all `ch_ready` = 0, header 0xA014 then 20 payload words back-to-back with `DEPTH` = 16.
  - On the 17th strobed word (16 already held): FIFO count = 1, state HUNT, `err_cnt` = 1.
  - Later non-sync words each increment `err_cnt`; the next 0xA2xx header is dispatched normally.
- **Timeout:** header 0xA204 plus 2 payload words, then silence. Expect `err_cnt` = 1 and state HUNT exactly `TIMEOUT` cycles after the FIFO empties. A following 0xA201, 0x5555 delivers 0x5555 on channel 2.
- **Reset mid-packet:** assert `reset` for 1 cycle after 2 of 4 payload words. All outputs are at reset values the next cycle. The next header is parsed from an empty FIFO.
